// File: rtl/dbus_arbiter_if.sv
// Shared dBUS types and the arbiter's bundled bus interface.
// Latency: n/a (type and port bundle only).
// Backpressure: n/a; the bus has no stall signal, and completion is reported by addr_ok/data_ok.
//
// Port summary (interface signals):
//   ptw_req / ptw_resp : page-table-walker request in, response out
//   lsu_req / lsu_resp : load/store unit request in, response out
//   dreq / dresp       : shared downstream dBUS request out, response in
//   grant              : one-hot owner (bit0 PTW, bit1 LSU), busy : transaction outstanding
package dbus_pkg;

  localparam logic [1:0] MSIZE1 = 2'd0;
  localparam logic [1:0] MSIZE2 = 2'd1;
  localparam logic [1:0] MSIZE4 = 2'd2;
  localparam logic [1:0] MSIZE8 = 2'd3;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

interface dbus_arbiter_if;
  import dbus_pkg::*;

  dbus_req_t  ptw_req;
  dbus_resp_t ptw_resp;
  dbus_req_t  lsu_req;
  dbus_resp_t lsu_resp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic [1:0] grant;
  logic       busy;

  // Arbiter view: it is the master of the shared downstream bus.
  modport master (
    input  ptw_req, lsu_req, dresp,
    output ptw_resp, lsu_resp, dreq, grant, busy
  );

  // Environment view: requesters and the downstream memory side.
  modport slave (
    output ptw_req, lsu_req, dresp,
    input  ptw_resp, lsu_resp, dreq, grant, busy
  );

endinterface

// File: rtl/dbus_arbiter.sv
// Arbitrates the PTW and LSU onto one dBUS port, PTW-priority with a bounded streak.
// Latency: dreq.valid rises one cycle after a request is sampled in IDLE; one DRAIN cycle follows data_ok.
// Backpressure: the latched request is held on dreq until data_ok; other requesters wait for the next IDLE.
//
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   io_dbus : dbus_arbiter_if.master bundle (ptw/lsu requests and responses, dreq/dresp, grant, busy)
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic           clk,
  input  logic           reset,
  dbus_arbiter_if.master io_dbus
);

  localparam logic [2:0] LP_MAX_STREAK = 3'(MAX_STREAK);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_PTW  = 2'b01;
  localparam logic [1:0] OWN_LSU  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e     r_state,  w_state_nxt;
  logic [1:0] r_owner,  w_owner_nxt;
  logic [2:0] r_streak, w_streak_nxt;
  dbus_req_t  r_req,    w_req_nxt;
  logic       r_abort,  w_abort_nxt;

  logic w_ptw_vld;
  logic w_lsu_vld;
  logic w_owner_vld;
  logic w_pick_ptw;
  logic w_fwd;
  logic w_suppress_dok;

  assign w_ptw_vld = io_dbus.ptw_req.valid;
  assign w_lsu_vld = io_dbus.lsu_req.valid;

  // Current valid of whichever requester owns the bus; used to detect aborts.
  always_comb begin
    w_owner_vld = 1'b0;
    if (r_owner == OWN_PTW) begin
      w_owner_vld = w_ptw_vld;
    end else if (r_owner == OWN_LSU) begin
      w_owner_vld = w_lsu_vld;
    end
  end

  // PTW wins unless the LSU has already been passed over MAX_STREAK times in a row.
  assign w_pick_ptw = w_ptw_vld && !(w_lsu_vld && (r_streak == LP_MAX_STREAK));

  // ---------------------------------------------------------------------------
  // FSM state register and per-transaction context
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_owner  <= OWN_NONE;
      r_streak <= 3'd0;
      r_req    <= '0;
      r_abort  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_streak <= w_streak_nxt;
      r_req    <= w_req_nxt;
      r_abort  <= w_abort_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_streak_nxt = r_streak;
    w_req_nxt    = r_req;
    w_abort_nxt  = r_abort;

    case (r_state)
      S_IDLE: begin
        if (w_ptw_vld || w_lsu_vld) begin
          w_state_nxt = S_BUSY;
          w_abort_nxt = 1'b0;
          if (w_pick_ptw) begin
            w_owner_nxt = OWN_PTW;
            w_req_nxt   = io_dbus.ptw_req;
            // Only count PTW wins that actually made the LSU wait.
            if (!w_lsu_vld) begin
              w_streak_nxt = 3'd0;
            end else if (r_streak != LP_MAX_STREAK) begin
              w_streak_nxt = r_streak + 3'd1;
            end
          end else begin
            w_owner_nxt  = OWN_LSU;
            w_req_nxt    = io_dbus.lsu_req;
            w_streak_nxt = 3'd0;
          end
          // The latched copy is what dreq shows in BUSY, so its valid is set here.
          w_req_nxt.valid = 1'b1;
        end
      end

      S_BUSY: begin
        // Once the owner lets go, its eventual data_ok is no longer wanted.
        if (!w_owner_vld) begin
          w_abort_nxt = 1'b1;
        end
        if (io_dbus.dresp.data_ok) begin
          w_state_nxt = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // One dead cycle so a requester's registered valid can fall before re-arbitration.
        w_state_nxt = S_IDLE;
        w_owner_nxt = OWN_NONE;
        w_abort_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_owner_nxt = OWN_NONE;
        w_abort_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registered state, so reset clears them at once.
  // ---------------------------------------------------------------------------
  assign w_fwd          = (r_state == S_BUSY);
  assign w_suppress_dok = r_abort || !w_owner_vld;

  always_comb begin
    io_dbus.dreq  = '0;
    io_dbus.grant = OWN_NONE;
    io_dbus.busy  = 1'b0;
    if (r_state == S_BUSY) begin
      io_dbus.dreq = r_req;
      io_dbus.busy = 1'b1;
    end
    if (r_state != S_IDLE) begin
      io_dbus.grant = r_owner;
    end
  end

  // Downstream response goes to the owner only; the other side sees zeros.
  always_comb begin
    io_dbus.ptw_resp = '0;
    io_dbus.lsu_resp = '0;
    if (w_fwd && (r_owner == OWN_PTW)) begin
      io_dbus.ptw_resp = io_dbus.dresp;
      if (w_suppress_dok) begin
        io_dbus.ptw_resp.data_ok = 1'b0;
      end
    end
    if (w_fwd && (r_owner == OWN_LSU)) begin
      io_dbus.lsu_resp = io_dbus.dresp;
      if (w_suppress_dok) begin
        io_dbus.lsu_resp.data_ok = 1'b0;
      end
    end
  end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 Parameter MAX_STREAK, default 4, SHALL set the maximum consecutive PTW grants allowed while the LSU waits (range 1-7).
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ptw_req  input  dbus_req_t  page-table-walker request (valid, addr, size, strobe, data).
REQ-005 ptw_resp  output  dbus_resp_t  response to the page-table walker.
REQ-006 lsu_req  input  dbus_req_t  load/store request.
REQ-007 lsu_resp  output  dbus_resp_t  response to the load/store unit.
REQ-008 dreq  output  dbus_req_t  shared downstream dBUS request.
REQ-009 dresp  input  dbus_resp_t  shared downstream dBUS response.
REQ-010 grant  output  2  one-hot owner: bit0 = PTW, bit1 = LSU, 00 = none.
REQ-011 busy  output  1  high when a downstream transaction is outstanding.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and DRAIN.
REQ-013 IDLE, no requester valid: stay in IDLE; dreq.valid = 0; grant = 00.
REQ-014 IDLE, one requester valid: latch that requester's addr/size/strobe/data; record the owner; enter BUSY on the next edge.
REQ-015 IDLE, both valid: grant PTW unless streak == MAX_STREAK, in which case grant LSU.
REQ-016 Arbitration latency: dreq.valid SHALL rise in the cycle after the requester's valid is first sampled in IDLE.
REQ-017 BUSY: dreq SHALL be driven from the latched copy with valid = 1, held constant until dresp.data_ok.
REQ-018 BUSY: dresp.addr_ok, data_ok and data SHALL be routed to the owner only; the non-owner sees addr_ok = 0, data_ok = 0, data = 0.
REQ-019 BUSY with dresp.data_ok = 1: enter DRAIN and drive dreq.valid = 0 from the next cycle.
REQ-020 DRAIN lasts one cycle, ignores both requesters, then returns to IDLE; this absorbs the requester's registered valid deassertion.
REQ-021 Owner drops valid during BUSY (abort): the latched request SHALL stay on dreq until data_ok; the data_ok pulse is then suppressed to the owner (owner data_ok = 0).
REQ-022 Non-owner valid during BUSY/DRAIN: no effect; it is considered in the next IDLE cycle.
REQ-023 streak, 3 bits: on a PTW grant with lsu_req.valid = 1, increment (saturate at MAX_STREAK); on a PTW grant with lsu_req.valid = 0, clear to 0; on an LSU grant, clear to 0.
REQ-024 grant SHALL equal the owner in BUSY and DRAIN, and 00 in IDLE.
REQ-025 busy SHALL be 1 in BUSY and 0 in IDLE and DRAIN.
REQ-026 The latched request and dreq.strobe/data SHALL be copied bit-exact; no resizing or address modification.

Reset
REQ-027 reset = 0 SHALL immediately (asynchronously) force state = IDLE, owner = none, streak = 0, all latched fields = 0, dreq = all zero, grant = 00, busy = 0, and both response ports = all zero.
REQ-028 Reset asserted mid-BUSY SHALL abandon the transaction; no data_ok is forwarded after reset, and the first post-reset edge with reset = 1 behaves as IDLE.

Verification
REQ-029 LSU-only load (addr 0x8000_0010, size MSIZE8), data_ok with data 0x1122_3344_5566_7788 at cycle 4 -> dreq.valid cycles 2-4, lsu_resp.data_ok = 1 with that data at cycle 4, grant = 10, IDLE at cycle 6.
REQ-030 PTW and LSU valid together in the same cycle -> PTW served first (grant 01), LSU served after PTW's DRAIN; LSU request fields unchanged on dreq.
REQ-031 PTW continuously valid, LSU valid, MAX_STREAK = 4 -> grants PTW, PTW, PTW, PTW, LSU; streak = 0 after the LSU grant.
REQ-032 LSU drops valid two cycles into BUSY (store, strobe 8'b0000_1111) -> dreq unchanged until data_ok; lsu_resp.data_ok stays 0; return to IDLE.
REQ-033 reset pulled low during PTW BUSY -> dreq.valid = 0 and grant = 00 in the same cycle; a late dresp.data_ok is not forwarded to ptw_resp.
REQ-034 Requester valid held for one cycle after data_ok -> DRAIN prevents a second grant; exactly one downstream transaction is observed.
